// File: rtl/div_sequencer.sv
// Sequential restoring divider producing a W.FRAC fixed-point quotient.
// Start and result use valid/ready handshakes; abort cancels whatever is in flight.
module div_sequencer #(
    parameter int W    = 4,
    parameter int FRAC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [W-1:0]        dividend,
    input  logic [W-1:0]        divisor,
    input  logic                abort,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [W+FRAC-1:0]   quotient,
    output logic [W-1:0]        remainder,
    output logic                div_by_zero,
    output logic                busy
);

    localparam int QW = W + FRAC;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [QW-1:0]   sr;
    logic [W-1:0]    pr;
    logic [W-1:0]    dsr;
    logic [CW-1:0]   cnt;

    logic [W:0]      pr_shift;
    logic [W:0]      pr_diff;
    logic [W-1:0]    pr_next;
    logic            q_bit;

    // The partial remainder never exceeds twice the divisor, so the sign
    // of the trial subtraction alone decides the quotient bit.
    always_comb begin
        pr_shift = {pr, sr[QW-1]};
        pr_diff  = pr_shift - {1'b0, dsr};
        q_bit    = ~pr_diff[W];
        pr_next  = q_bit ? pr_diff[W-1:0] : pr_shift[W-1:0];
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);

    // Quotient bits are shifted into the bottom of the dividend register as
    // its top bits are consumed, so it holds the full quotient at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            pr          <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && !abort) begin
                        sr  <= QW'(dividend) << FRAC;
                        dsr <= divisor;
                        pr  <= '0;
                        cnt <= CW'(QW - 1);
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        pr <= pr_next;
                        sr <= {sr[QW-2:0], q_bit};
                        if (cnt == '0) begin
                            state       <= DONE;
                            quotient    <= {sr[QW-2:0], q_bit};
                            remainder   <= pr_next;
                            div_by_zero <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort || res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer at W=4, FRAC=4.
// Expected quotients are floor(a*16/b) and remainders (a*16) mod b, worked by hand.
module tb_div_sequencer;

    localparam int W    = 4;
    localparam int FRAC = 4;
    localparam int QW   = W + FRAC;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          abort;
    logic          res_valid;
    logic          res_ready;
    logic [QW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;
    logic          busy;

    int compared;
    int mismatched;
    int lat;
    int seen;

    div_sequencer #(.W(W), .FRAC(FRAC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .abort       (abort),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ab, input logic rr);
        start_valid = sv;
        dividend    = a;
        divisor     = b;
        abort       = ab;
        res_ready   = rr;
        tick();
    endtask

    // Counts edges after the accept edge until res_valid shows, scrambling operands meanwhile.
    task automatic waitResult(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        start_valid = 1'b0;
        dividend    = ~a;
        divisor     = ~b;
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        applyStimulus(1'b1, a, b, 1'b0, 1'b0);
        waitResult(a, b, n);
    endtask

    task automatic releaseResult(input string tag);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        res_ready = 1'b0;
        checkOutput({tag, "_idle"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        dividend    = '0;
        divisor     = '0;
        abort       = 1'b0;
        res_ready   = 1'b0;

        #2;
        checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        checkOutput("rst_res_valid",   32'(res_valid),   32'd0);
        checkOutput("rst_quotient",    32'(quotient),    32'h00);
        checkOutput("rst_remainder",   32'(remainder),   32'h0);
        checkOutput("rst_dbz",         32'(div_by_zero), 32'd0);

        // Release between edges so the very next edge accepts 7/2.
        #10;
        rst_n       = 1'b1;
        start_valid = 1'b1;
        dividend    = 4'd7;
        divisor     = 4'd2;
        tick();
        checkOutput("first_accept_busy", 32'(busy), 32'd1);
        waitResult(4'd7, 4'd2, lat);
        checkOutput("d7_2_latency",   32'(lat),         32'd8);
        checkOutput("d7_2_res_valid", 32'(res_valid),   32'd1);
        checkOutput("d7_2_quotient",  32'(quotient),    32'h38);
        checkOutput("d7_2_remainder", 32'(remainder),   32'h0);
        checkOutput("d7_2_dbz",       32'(div_by_zero), 32'd0);
        checkOutput("d7_2_busy",      32'(busy),        32'd1);

        // Release while start_valid is high: that edge only returns to IDLE.
        applyStimulus(1'b1, 4'd3, 4'd1, 1'b0, 1'b1);
        res_ready = 1'b0;
        start_valid = 1'b0;
        checkOutput("release_idle",      32'(start_ready), 32'd1);
        checkOutput("release_hold_quot", 32'(quotient),    32'h38);
        tick();
        checkOutput("no_accept_on_release", 32'(busy), 32'd0);

        // Zero divisor goes straight to DONE on the accept edge.
        runDiv(4'd9, 4'd0, lat);
        checkOutput("d9_0_latency",   32'(lat),         32'd0);
        checkOutput("d9_0_res_valid", 32'(res_valid),   32'd1);
        checkOutput("d9_0_dbz",       32'(div_by_zero), 32'd1);
        checkOutput("d9_0_quotient",  32'(quotient),    32'h00);
        checkOutput("d9_0_remainder", 32'(remainder),   32'h0);
        releaseResult("d9_0");

        runDiv(4'd0, 4'd5, lat);
        checkOutput("d0_5_latency",   32'(lat),         32'd8);
        checkOutput("d0_5_quotient",  32'(quotient),    32'h00);
        checkOutput("d0_5_remainder", 32'(remainder),   32'h0);
        checkOutput("d0_5_dbz",       32'(div_by_zero), 32'd0);
        releaseResult("d0_5");

        runDiv(4'd15, 4'd1, lat);
        checkOutput("d15_1_quotient",  32'(quotient),  32'hF0);
        checkOutput("d15_1_remainder", 32'(remainder), 32'h0);
        releaseResult("d15_1");

        runDiv(4'd1, 4'd3, lat);
        checkOutput("d1_3_quotient",  32'(quotient),  32'h05);
        checkOutput("d1_3_remainder", 32'(remainder), 32'h1);

        // Backpressure: result must hold while new starts and operands churn.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'(i + 2), 4'(i + 7), 1'b0, 1'b0);
            checkOutput("bp_res_valid",   32'(res_valid),   32'd1);
            checkOutput("bp_start_ready", 32'(start_ready), 32'd0);
            checkOutput("bp_quotient",    32'(quotient),    32'h05);
            checkOutput("bp_remainder",   32'(remainder),   32'h1);
        end
        applyStimulus(1'b1, 4'd6, 4'd3, 1'b0, 1'b1);
        checkOutput("bp_release_idle", 32'(start_ready), 32'd1);
        applyStimulus(1'b1, 4'd6, 4'd3, 1'b0, 1'b0);
        checkOutput("bp_next_accept", 32'(busy), 32'd1);
        waitResult(4'd6, 4'd3, lat);
        checkOutput("d6_3_latency",  32'(lat),      32'd8);
        checkOutput("d6_3_quotient", 32'(quotient), 32'h20);
        releaseResult("d6_3");

        // Abort on the 4th CALC edge; the previous result must survive.
        applyStimulus(1'b1, 4'd12, 4'd5, 1'b0, 1'b0);
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_calc_idle",  32'(start_ready), 32'd1);
        checkOutput("abort_calc_quot",  32'(quotient),    32'h20);
        checkOutput("abort_calc_rem",   32'(remainder),   32'h0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid) seen++;
        end
        checkOutput("abort_calc_no_valid", 32'(seen), 32'd0);

        applyStimulus(1'b1, 4'd5, 4'd1, 1'b1, 1'b0);
        checkOutput("abort_idle_no_accept", 32'(busy), 32'd0);
        abort = 1'b0;
        start_valid = 1'b0;

        // Abort in DONE drops the handshake but leaves the result registers.
        runDiv(4'd5, 4'd5, lat);
        checkOutput("d5_5_quotient", 32'(quotient), 32'h10);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        abort = 1'b0;
        checkOutput("abort_done_idle", 32'(start_ready), 32'd1);
        checkOutput("abort_done_quot", 32'(quotient),    32'h10);

        // Asynchronous reset in the middle of CALC, asserted between edges.
        applyStimulus(1'b1, 4'd13, 4'd3, 1'b0, 1'b0);
        start_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_start_ready", 32'(start_ready), 32'd1);
        checkOutput("midrst_busy",        32'(busy),        32'd0);
        checkOutput("midrst_res_valid",   32'(res_valid),   32'd0);
        checkOutput("midrst_quotient",    32'(quotient),    32'h00);
        checkOutput("midrst_remainder",   32'(remainder),   32'h0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid) seen++;
        end
        checkOutput("midrst_no_valid", 32'(seen), 32'd0);

        runDiv(4'd6, 4'd4, lat);
        checkOutput("d6_4_latency",   32'(lat),       32'd8);
        checkOutput("d6_4_quotient",  32'(quotient),  32'h18);
        checkOutput("d6_4_remainder", 32'(remainder), 32'h0);
        releaseResult("d6_4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
